// File: rtl/alu_16_bit_nibble_seq.sv
// Purpose: sequences a 16-bit ALU operation through an external 4-bit CLA slice, one nibble per cycle, LSB first.
// Latency: done pulses in the 5th cycle after the start edge (4 RUN cycles, then 1 DONE cycle).
// Backpressure: none; start is only honoured in IDLE, and result/flags hold until the next operation overwrites them.
module alu_16_bit_nibble_seq #(
  parameter logic [2:0] SUB_OP = 3'b110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  ALUop,
  output logic [3:0]  slice_a,
  output logic [3:0]  slice_b,
  output logic        slice_c_in,
  output logic [2:0]  slice_ALUop,
  input  logic [3:0]  slice_result,
  input  logic        slice_p,
  input  logic        slice_g,
  output logic [15:0] result,
  output logic        c_out,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic        carry;
  logic        carry_nxt;
  logic [15:0] lat_a;
  logic [15:0] lat_b;
  logic [2:0]  lat_op;
  logic [3:0]  nib_lo;

  // Carry leaving the current nibble, from the slice's group propagate/generate.
  assign carry_nxt = slice_g | (slice_p & carry);
  assign nib_lo    = {idx, 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> RUN on start, RUN -> DONE after nibble 3, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, nibble walk, carry chain and result assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= 2'd0;
      carry  <= 1'b0;
      lat_a  <= 16'd0;
      lat_b  <= 16'd0;
      lat_op <= 3'd0;
      result <= 16'd0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_a  <= a;
            lat_b  <= b;
            lat_op <= ALUop;
            idx    <= 2'd0;
            // Subtract is a + ~b + 1: the slice inverts b, the +1 enters here.
            carry  <= (ALUop == SUB_OP);
          end
        end
        RUN: begin
          result[nib_lo +: 4] <= slice_result;
          carry               <= carry_nxt;
          if (idx != 2'd3) begin
            idx <= idx + 2'd1;
          end else begin
            c_out <= carry_nxt;
            // Upper nibble is being written this edge, so test it from the slice directly.
            zero  <= ({slice_result, result[11:0]} == 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

  // Slice drive: current nibble and carry in RUN, quiet zeros otherwise.
  always_comb begin
    slice_a    = 4'd0;
    slice_b    = 4'd0;
    slice_c_in = 1'b0;
    if (state == RUN) begin
      slice_a    = lat_a[nib_lo +: 4];
      slice_b    = lat_b[nib_lo +: 4];
      slice_c_in = carry;
    end
  end

  assign slice_ALUop = lat_op;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_alu_16_bit_nibble_seq.sv
// Purpose: randomized scoreboard bench for the nibble-sequenced ALU, with a behavioural 4-bit slice attached.
// Latency: expects done 4 cycle counts after the accepting edge, per-nibble slice drive each RUN cycle.
// Backpressure: stimulus only issues in IDLE, except the held-start sequence which relies on the DUT ignoring it.
module tb_alu_16_bit_nibble_seq;

  localparam logic [2:0] SUB    = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic [2:0]  ALUop;
  logic [3:0]  slice_a, slice_b;
  logic        slice_c_in;
  logic [2:0]  slice_ALUop;
  logic [3:0]  slice_result;
  logic        slice_p, slice_g;
  logic [15:0] result;
  logic        c_out, zero, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] beff;
    logic        cin0;
    logic [2:0]  op;
    int          start_cyc;
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        arith;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   k;

  alu_16_bit_nibble_seq #(.SUB_OP(SUB)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUop(ALUop),
    .slice_a(slice_a), .slice_b(slice_b), .slice_c_in(slice_c_in), .slice_ALUop(slice_ALUop),
    .slice_result(slice_result), .slice_p(slice_p), .slice_g(slice_g),
    .result(result), .c_out(c_out), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External 4-bit slice: inverts b for subtract, AND/OR for logic ops, arithmetic otherwise.
  logic [3:0] s_beff;
  logic [4:0] s_gsum;
  always_comb begin
    s_beff       = (slice_ALUop == SUB) ? ~slice_b : slice_b;
    s_gsum       = {1'b0, slice_a} + {1'b0, s_beff};
    slice_g      = s_gsum[4];
    slice_p      = &(slice_a ^ s_beff);
    slice_result = s_gsum[3:0] + {3'b000, slice_c_in};
    if (slice_ALUop == OP_AND) slice_result = slice_a & slice_b;
    if (slice_ALUop == OP_OR)  slice_result = slice_a | slice_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: 17-bit sum gives the carry out of bit 15 directly.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] op, input int sc);
    exp_t r;
    logic [16:0] full;
    r.a = ma; r.b = mb; r.op = op; r.start_cyc = sc;
    r.cin0  = (op == SUB);
    r.beff  = (op == SUB) ? ~mb : mb;
    full    = {1'b0, ma} + {1'b0, r.beff} + {16'd0, r.cin0};
    r.co    = full[16];
    r.arith = 1'b1;
    r.res   = full[15:0];
    if (op == OP_AND) begin r.res = ma & mb; r.arith = 1'b0; end
    if (op == OP_OR)  begin r.res = ma | mb; r.arith = 1'b0; end
    r.z = (r.res == 16'd0);
    return r;
  endfunction

  // Carry into nibble n: carry out of the low 4n bits of the word-level sum.
  function automatic logic carry_into(input exp_t r, input int n);
    logic [15:0] m;
    logic [16:0] s;
    m = (n == 0) ? 16'd0 : (16'hFFFF >> (16 - 4 * n));
    s = {1'b0, r.a & m} + {1'b0, r.beff & m} + {16'd0, r.cin0};
    return s[4 * n];
  endfunction

  // Monitor: per-RUN-cycle slice drive and completion checks against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (sb.size() == 0) begin
          chk("busy_without_op", 32'd1, 32'd0);
        end else begin
          k = cyc - sb[0].start_cyc;
          chk("run_cycle_in_range", (k >= 0 && k < 4) ? 32'd1 : 32'd0, 32'd1);
          chk("slice_a", {28'd0, slice_a}, (sb[0].a >> (4 * k)) & 16'hF);
          chk("slice_b", {28'd0, slice_b}, (sb[0].b >> (4 * k)) & 16'hF);
          chk("slice_c_in", {31'd0, slice_c_in}, {31'd0, carry_into(sb[0], k)});
          chk("slice_ALUop", {29'd0, slice_ALUop}, {29'd0, sb[0].op});
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.start_cyc + 4);
          chk("result", {16'd0, result}, {16'd0, e.res});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          if (e.arith) chk("c_out", {31'd0, c_out}, {31'd0, e.co});
          chk("busy_in_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("wait_done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] iop);
    wait_idle();
    start = 1'b1; a = ia; b = ib; ALUop = iop;
    sb.push_back(model(ia, ib, iop, cyc + 1));
    @(negedge clk); #1;
    // Scramble inputs while in flight; the latched copy must be used.
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); ALUop = 3'($urandom);
  endtask

  logic [2:0] op_tbl [4];

  initial begin
    op_tbl[0] = OP_AND; op_tbl[1] = OP_OR; op_tbl[2] = OP_ADD; op_tbl[3] = SUB;
    reset = 1'b1; start = 1'b0; a = 16'h1234; b = 16'h5678; ALUop = SUB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_slice_a", {28'd0, slice_a}, 32'd0);
    chk("rst_slice_c_in", {31'd0, slice_c_in}, 32'd0);
    chk("rst_slice_ALUop", {29'd0, slice_ALUop}, 32'd0);
    #1 reset = 1'b0;

    issue(16'h00FF, 16'h0001, OP_ADD);
    issue(16'h0005, 16'h0007, SUB);
    issue(16'h0007, 16'h0005, SUB);
    issue(16'hFFFF, 16'h0001, OP_ADD);
    issue(16'h0000, 16'h0000, SUB);
    issue(16'hF0F0, 16'h0F0F, OP_AND);

    for (int i = 0; i < 30; i++) begin
      issue(16'($urandom), 16'($urandom), op_tbl[$urandom_range(0, 3)]);
    end

    // Start held high with operands changing every cycle: one accept every 6 cycles.
    wait_idle();
    for (int i = 0; i < 18; i++) begin
      start = 1'b1; a = 16'($urandom); b = 16'($urandom); ALUop = op_tbl[$urandom_range(0, 3)];
      if (i % 6 == 0) sb.push_back(model(a, b, ALUop, cyc + 1));
      @(negedge clk); #1;
    end
    start = 1'b0;

    // Reset while idx==2 aborts the operation with no done pulse.
    wait_idle();
    start = 1'b1; a = 16'hABCD; b = 16'h1111; ALUop = OP_ADD;
    sb.push_back(model(a, b, ALUop, cyc + 1));
    @(negedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    reset = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_slice_b", {28'd0, slice_b}, 32'd0);
    reset = 1'b0;
    repeat (8) begin @(negedge clk); #1; end
    issue(16'h1234, 16'h4321, SUB);
    issue(16'h8000, 16'h8000, OP_ADD);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_16_bit_nibble_seq.md
ALU_16_BIT_NIBBLE_SEQ -- requirements
Module: alu_16_bit_nibble_seq

Purpose: multi-cycle 16-bit ALU controller. It drives one external 4-bit carry-lookahead ALU slice, one nibble per cycle, LSB first, and assembles a 16-bit result plus carry/zero flags.

Interface
REQ-001 The block SHALL have exactly one clock and one synchronous, active-high reset; both are listed first below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a  input  16  operand A.
REQ-006 b  input  16  operand B, un-inverted (the slice inverts it for subtract).
REQ-007 ALUop  input  3  operation code, passed through unchanged to the slice.
REQ-008 slice_a  output  4  current nibble of latched A, to the slice a.
REQ-009 slice_b  output  4  current nibble of latched B, to the slice b_initial.
REQ-010 slice_c_in  output  1  carry into the current nibble, to the slice c_in.
REQ-011 slice_ALUop  output  3  latched ALUop, to the slice ALUop.
REQ-012 slice_result  input  4  slice result for the current nibble (combinational, same cycle).
REQ-013 slice_p, slice_g  input  1 each  slice group propagate and generate.
REQ-014 result  output  16  assembled result register.
REQ-015 c_out  output  1  carry out of bit 15.
REQ-016 zero  output  1  result == 0.
REQ-017 busy  output  1  high while in RUN.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 Parameter SUB_OP, default 3'b110: the ALUop value that selects subtract.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN and DONE. RUN SHALL contain a 2-bit nibble index idx.
REQ-021 In IDLE with start=1, the next edge SHALL latch a, b and ALUop, set idx=0, and enter RUN.
REQ-022 On that same edge, the carry register SHALL load 1 if ALUop==SUB_OP, and 0 otherwise.
REQ-023 In RUN, slice_a SHALL equal latched_a[4*idx+3:4*idx] and slice_b SHALL equal latched_b[4*idx+3:4*idx].
REQ-024 In RUN, slice_c_in SHALL equal the carry register.
REQ-025 On each RUN edge, result[4*idx+3:4*idx] SHALL load slice_result, and the carry register SHALL load slice_g | (slice_p & carry).
REQ-026 On each RUN edge with idx<3, idx SHALL increment.
REQ-027 On the RUN edge with idx==3, the FSM SHALL enter DONE.
REQ-028 On that idx==3 edge, c_out SHALL load the new carry value, and zero SHALL load 1 iff the full 16-bit result being written is 0.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 Latency: done SHALL be high in the 5th cycle after the edge that samples start, i.e. 4 RUN cycles followed by 1 DONE cycle.
REQ-031 A start request SHALL be ignored in RUN and in DONE. An operation SHALL accept a new start no earlier than the IDLE cycle after DONE.
REQ-032 Changes on a, b or ALUop after the start edge SHALL NOT affect the operation in flight.
REQ-033 result, c_out and zero SHALL hold their values from DONE until the next operation's RUN edges overwrite them.
REQ-034 result nibbles SHALL be updated progressively during RUN. result is valid only when done=1 or afterward.
REQ-035 busy SHALL equal (state==RUN).
REQ-036 For logical ops, the carry chain SHALL still be computed. c_out is then don't-care for checking but SHALL be deterministic.
REQ-037 Outside RUN, slice_a, slice_b and slice_c_in SHALL be 0, and slice_ALUop SHALL hold its latched value.

Reset
REQ-038 While reset=1 at a clock edge: state SHALL go to IDLE; idx, carry, result, c_out and zero SHALL go to 0; the latched operands SHALL go to 0; busy and done SHALL be 0.
REQ-039 Reset SHALL override start and SHALL abort any operation in RUN or DONE; no done pulse SHALL follow.

Verification
REQ-040 ADD (op != SUB_OP), a=0x00FF, b=0x0001 -> done in cycle 5; result=0x0100, c_out=0, zero=0.
REQ-041 SUB_OP, a=0x0005, b=0x0007 -> result=0xFFFE, c_out=0, zero=0. SUB_OP, a=0x0007, b=0x0005 -> result=0x0002, c_out=1.
REQ-042 ADD, a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1, zero=1. This checks the carry ripple through all four nibbles.
REQ-043 start held high continuously, with a and b changed during RUN -> exactly one done per 5 cycles plus 1 IDLE cycle. Results SHALL match the operands latched at each start.
REQ-044 reset asserted at idx==2 -> next cycle shows state IDLE, result=0, busy=0; no done pulse. A subsequent start then completes normally.
REQ-045 Per-cycle check during RUN: slice_a, slice_b and slice_c_in match the expected nibble and carry for idx 0..3.
